// File: rtl/eq_band_mixer_if.sv
// Band-mixer port bundle: band inputs, gain access and mixed stereo output.
interface eq_band_mixer_if #(
  parameter int NUM_BANDS = 4
);
  logic                       audio_en;
  logic                       in_valid;
  logic [NUM_BANDS-1:0][47:0] l_band_in;
  logic [NUM_BANDS-1:0][47:0] r_band_in;
  logic                       gain_wr_en;
  logic [5:0]                 gain_select;
  logic [15:0]                gain_wr_data;
  logic [15:0]                gain_rd_data;
  logic [23:0]                l_data_out;
  logic [23:0]                r_data_out;
  logic                       out_valid;
  logic                       overrun;
  logic                       busy;

  modport master (
    output audio_en, in_valid, l_band_in, r_band_in,
    output gain_wr_en, gain_select, gain_wr_data,
    input  gain_rd_data, l_data_out, r_data_out,
    input  out_valid, overrun, busy
  );

  modport slave (
    input  audio_en, in_valid, l_band_in, r_band_in,
    input  gain_wr_en, gain_select, gain_wr_data,
    output gain_rd_data, l_data_out, r_data_out,
    output out_valid, overrun, busy
  );
endinterface

// File: rtl/eq_band_mixer.sv
// Per-band gain scaling and stereo band summation with one shared
// sequential MAC pass, followed by rounding and 24-bit saturation.
module eq_band_mixer #(
  parameter int NUM_BANDS = 4,
  parameter int IN_SHIFT  = 15,
  parameter int GAIN_FRAC = 14
) (
  input logic          clk,
  input logic          reset_n,
  eq_band_mixer_if.slave bus
);
  localparam int IW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int S  = IN_SHIFT + GAIN_FRAC;
  localparam logic signed [65:0] RND = 66'sd1 <<< (S - 1);

  typedef enum logic [2:0] {
    IDLE, MAC, FLUSH, ROUND, OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [15:0] gain   [NUM_BANDS];
  logic signed [15:0] shadow [NUM_BANDS];
  logic signed [47:0] hold_l [NUM_BANDS];
  logic signed [47:0] hold_r [NUM_BANDS];

  logic [IW-1:0]      idx;
  logic signed [47:0] cur_l, cur_r;
  logic signed [15:0] cur_g;
  logic signed [63:0] prod_l, prod_r;
  logic signed [65:0] acc_l, acc_r;
  logic signed [65:0] rnd_l, rnd_r;
  logic [23:0]        l_q, r_q;
  logic               ovr_q;
  logic               accept, last, add_en;

  assign accept = bus.audio_en && bus.in_valid
               && (state == IDLE);
  assign last   = (idx == IW'(NUM_BANDS - 1));
  assign add_en = (state == FLUSH)
               || ((state == MAC) && (idx != '0));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.audio_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (bus.in_valid) state_nxt = MAC;
        MAC:   if (last) state_nxt = FLUSH;
        FLUSH: state_nxt = ROUND;
        ROUND: state_nxt = OUT;
        OUT:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANDS; i++)
        gain[i] <= 16'sh4000;
    end else if (bus.gain_wr_en) begin
      for (int i = 0; i < NUM_BANDS; i++)
        if (bus.gain_select == 6'(i))
          gain[i] <= bus.gain_wr_data;
    end
  end

  // Shadow copy takes the pre-write gain on a same-edge write.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        hold_l[i] <= bus.l_band_in[i];
        hold_r[i] <= bus.r_band_in[i];
        shadow[i] <= gain[i];
      end
    end
  end

  always_comb begin
    cur_l = '0;
    cur_r = '0;
    cur_g = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (idx == IW'(i)) begin
        cur_l = hold_l[i];
        cur_r = hold_r[i];
        cur_g = shadow[i];
      end
    end
  end

  always_comb begin
    bus.gain_rd_data = '0;
    for (int i = 0; i < NUM_BANDS; i++)
      if (bus.gain_select == 6'(i))
        bus.gain_rd_data = gain[i];
  end

  assign rnd_l = (acc_l + RND) >>> S;
  assign rnd_r = (acc_r + RND) >>> S;

  function automatic logic [23:0] sat(
    input logic signed [65:0] v
  );
    if (v > 66'sd8388607)       return 24'h7fffff;
    else if (v < -66'sd8388608) return 24'h800000;
    else                        return v[23:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || !bus.audio_en) begin
      idx    <= '0;
      prod_l <= '0;
      prod_r <= '0;
      acc_l  <= '0;
      acc_r  <= '0;
      l_q    <= '0;
      r_q    <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (bus.in_valid && (state != IDLE))
        ovr_q <= 1'b1;
      if (accept) begin
        idx   <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end
      if (state == MAC) begin
        prod_l <= 64'(cur_l) * 64'(cur_g);
        prod_r <= 64'(cur_r) * 64'(cur_g);
        idx    <= last ? '0 : idx + 1'b1;
      end
      if (add_en) begin
        acc_l <= acc_l + 66'(prod_l);
        acc_r <= acc_r + 66'(prod_r);
      end
      if (state == ROUND) begin
        l_q <= sat(rnd_l);
        r_q <= sat(rnd_r);
      end
    end
  end

  assign bus.l_data_out = l_q;
  assign bus.r_data_out = r_q;
  assign bus.overrun    = ovr_q;
  assign bus.out_valid  = (state == OUT);
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_eq_band_mixer.sv
// Randomized bench for eq_band_mixer with a cycle-level behavioural
// model plus directed cases pinned to hand-computed results.
module tb_eq_band_mixer;
  localparam int NB  = 4;
  localparam int S   = 15 + 14;
  localparam int LAT = NB + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;

  eq_band_mixer_if #(.NUM_BANDS(NB)) bus();

  eq_band_mixer #(.NUM_BANDS(NB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model state: gains, outputs, cycle index, and cycle of the next out_valid
  logic signed [15:0] m_gain [NB];
  int m_l = 0, m_r = 0, m_pl = 0, m_pr = 0;
  bit m_ovr = 1'b0;
  int m_cyc = 0;
  int m_due = -1;

  function automatic int mix(
    input logic [NB-1:0][47:0] b,
    input logic signed [15:0] g [NB]
  );
    logic signed [95:0] s;
    s = '0;
    for (int i = 0; i < NB; i++)
      s = s + 96'($signed(b[i])) * 96'(g[i]);
    s = (s + (96'sd1 <<< (S - 1))) >>> S;
    if (s > 96'sd8388607) return 8388607;
    if (s < -96'sd8388608) return -8388608;
    return int'(s);
  endfunction

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) m_gain[i] <= 16'sh4000;
      m_l <= 0; m_r <= 0; m_ovr <= 1'b0; m_due <= -1;
    end else begin
      if (bus.gain_wr_en && int'(bus.gain_select) < NB)
        m_gain[bus.gain_select] <= bus.gain_wr_data;
      if (!bus.audio_en) begin
        m_l <= 0; m_r <= 0; m_ovr <= 1'b0; m_due <= -1;
      end else begin
        if (bus.in_valid) begin
          if (m_due >= m_cyc) m_ovr <= 1'b1;
          else begin
            m_pl  <= mix(bus.l_band_in, m_gain);
            m_pr  <= mix(bus.r_band_in, m_gain);
            m_due <= m_cyc + LAT;
          end
        end
        if (m_due == m_cyc + 1) begin
          m_l <= m_pl;
          m_r <= m_pr;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int sel;
      int erd;
      sel = int'(bus.gain_select);
      erd = (sel < NB) ? int'(m_gain[sel[1:0]]) & 32'hffff : 0;
      chk("busy", int'(bus.busy), int'(m_due >= m_cyc));
      chk("out_valid", int'(bus.out_valid), int'(m_due == m_cyc));
      chk("overrun", int'(bus.overrun), int'(m_ovr));
      chk("l_data", int'($signed(bus.l_data_out)), m_l);
      chk("r_data", int'($signed(bus.r_data_out)), m_r);
      chk("gain_rd", int'(bus.gain_rd_data), erd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] b48(input longint v);
    return v[47:0];
  endfunction

  task automatic clear_bands();
    for (int i = 0; i < NB; i++) begin
      bus.l_band_in[i] = '0;
      bus.r_band_in[i] = '0;
    end
  endtask

  task automatic wr_gain(input int b, input logic [15:0] g);
    bus.gain_select  = 6'(b);
    bus.gain_wr_data = g;
    bus.gain_wr_en   = 1'b1;
    step();
    bus.gain_wr_en   = 1'b0;
  endtask

  task automatic pulse_wait(input string nm);
    int lat;
    lat = -1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      step();
    end
    chk({nm, "_latency"}, lat, LAT);
  endtask

  initial begin
    bus.audio_en     = 1'b1;
    bus.in_valid     = 1'b0;
    bus.gain_wr_en   = 1'b0;
    bus.gain_select  = '0;
    bus.gain_wr_data = '0;
    clear_bands();
    repeat (3) step();
    reset_n = 1'b1;
    chk_on  = 1'b1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_l", int'($signed(bus.l_data_out)), 0);
    chk("rst_gain0", int'(bus.gain_rd_data), 'h4000);

    // unity mix
    bus.l_band_in[0] = b48(64'sd1000 <<< 15);
    bus.r_band_in[2] = b48(-(64'sd2000 <<< 15));
    pulse_wait("unity");
    chk("unity_l", int'($signed(bus.l_data_out)), 1000);
    chk("unity_r", int'($signed(bus.r_data_out)), -2000);
    step();

    // gain scaling: 0.5 and -1.0
    clear_bands();
    wr_gain(0, 16'h2000);
    wr_gain(1, 16'hC000);
    bus.l_band_in[0] = b48(64'sd1000 <<< 15);
    bus.l_band_in[1] = b48(64'sd1000 <<< 15);
    pulse_wait("scale");
    chk("scale_l", int'($signed(bus.l_data_out)), -500);
    chk("scale_r", int'($signed(bus.r_data_out)), 0);
    step();

    // rounding half toward +inf, out-of-range gain access
    wr_gain(0, 16'h4000);
    wr_gain(1, 16'h4000);
    clear_bands();
    bus.l_band_in[0] = b48((64'sd5 <<< 15) + (64'sd1 <<< 14));
    pulse_wait("rnd_pos");
    chk("rnd_pos_l", int'($signed(bus.l_data_out)), 6);
    step();
    bus.l_band_in[0] = b48(-((64'sd5 <<< 15) + (64'sd1 <<< 14)));
    pulse_wait("rnd_neg");
    chk("rnd_neg_l", int'($signed(bus.l_data_out)), -5);
    step();
    wr_gain(9, 16'h1234);
    chk("rd_sel9", int'(bus.gain_rd_data), 0);
    bus.gain_select = 6'd0;
    #1 chk("rd_sel0", int'(bus.gain_rd_data), 'h4000);

    // saturation both ways
    clear_bands();
    bus.l_band_in[0] = b48(64'sd8388607 <<< 15);
    bus.l_band_in[1] = b48(64'sd8388607 <<< 15);
    pulse_wait("sat_pos");
    chk("sat_pos_l", int'(bus.l_data_out), 'h7fffff);
    step();
    bus.l_band_in[0] = b48(-(64'sd8388608 <<< 15));
    bus.l_band_in[1] = b48(-(64'sd8388608 <<< 15));
    pulse_wait("sat_neg");
    chk("sat_neg_l", int'(bus.l_data_out), 'h800000);
    step();

    // shadow gains and overrun
    clear_bands();
    bus.l_band_in[0] = b48(64'sd1000 <<< 15);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.gain_select  = 6'd0;
    bus.gain_wr_data = 16'h0000;
    bus.gain_wr_en   = 1'b1;
    step();
    bus.gain_wr_en = 1'b0;
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("shadow_valid", int'(bus.out_valid), 1);
    chk("shadow_l", int'($signed(bus.l_data_out)), 1000);
    chk("ovr_set", int'(bus.overrun), 1);
    step();
    pulse_wait("zero_gain");
    chk("zero_gain_l", int'($signed(bus.l_data_out)), 0);
    step();
    bus.audio_en = 1'b0;
    step();
    bus.audio_en = 1'b1;
    chk("ovr_clear", int'(bus.overrun), 0);

    // abort by reset mid-pass
    bus.l_band_in[1] = b48(64'sd777 <<< 15);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_l", int'($signed(bus.l_data_out)), 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (bus.out_valid) seen++;
        step();
      end
      chk("abort_no_valid", seen, 0);
    end
    bus.gain_select = 6'd0;
    #1 chk("abort_gain0", int'(bus.gain_rd_data), 'h4000);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NB; i++) begin
        longint v;
        v = longint'({$urandom, $urandom}) >>> $urandom_range(0, 40);
        bus.l_band_in[i] = b48(v);
        v = longint'({$urandom, $urandom}) >>> $urandom_range(0, 40);
        bus.r_band_in[i] = b48(v);
      end
      bus.gain_wr_en   = ($urandom_range(0, 4) == 0);
      bus.gain_select  = 6'($urandom_range(0, 9));
      bus.gain_wr_data = 16'($urandom);
      bus.audio_en     = ($urandom_range(0, 49) != 0);
      reset_n          = ($urandom_range(0, 199) != 0);
      step();
    end
    bus.in_valid   = 1'b0;
    bus.gain_wr_en = 1'b0;
    bus.audio_en   = 1'b1;
    reset_n        = 1'b1;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
